// File: rtl/snake_pkg.sv
// Shared definitions for the snake game plotting path: FSM encoding,
// screen geometry, cell size and the packed draw-request record.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int CELL_SIZE = 4;
  localparam int CELL_PIX  = CELL_SIZE * CELL_SIZE;
  localparam int COLOUR_W  = 3;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int REQ_W     = X_W + Y_W + COLOUR_W;

  // One queued cell: top-left corner plus fill colour.
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } plot_req_t;

endpackage

// File: rtl/plot_req_fifo.sv
// Small synchronous FIFO holding pending cell draw requests.
// The head entry is always visible on 'head' (first-word read port).
module plot_req_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = REQ_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; storage needs no reset because empty gates all reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the pushed request into the slot addressed by the write pointer.
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) mem[gi] <= push_data;
      end
    end
  endgenerate

endmodule

// File: rtl/block_plot_engine.sv
// Expands queued 4x4 cell draw requests and full-screen clear sweeps into
// single-pixel plots for vga_adapter. All vga_* outputs are registered.
module block_plot_engine
  import snake_pkg::*;
#(
  parameter int            FIFO_DEPTH   = 4,
  parameter int            SCREEN_W     = snake_pkg::SCREEN_W,
  parameter int            SCREEN_H     = snake_pkg::SCREEN_H,
  parameter logic [2:0]    CLEAR_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [X_W-1:0]       req_x,
  input  logic [Y_W-1:0]       req_y,
  input  logic [COLOUR_W-1:0]  req_colour,
  input  logic                 clear_req,
  output logic                 busy,
  output logic                 done,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [COLOUR_W-1:0]  vga_colour,
  output logic                 vga_plot
);

  localparam logic [X_W-1:0] X_LAST   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   X_LIMIT  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   Y_LIMIT  = (Y_W+1)'(SCREEN_H);
  localparam logic [3:0]     OFF_LAST = 4'(CELL_PIX - 1);

  state_t                state_q, state_d;
  logic [3:0]            offset_q, offset_d;
  logic [X_W-1:0]        sweep_x_q, sweep_x_d;
  logic [Y_W-1:0]        sweep_y_q, sweep_y_d;
  plot_req_t             cur_q, cur_d;
  logic                  clear_pending_q, clear_pending_d;
  logic [X_W-1:0]        vga_x_q, vga_x_d;
  logic [Y_W-1:0]        vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic                  vga_plot_q, vga_plot_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [REQ_W-1:0]      fifo_head;
  logic [X_W-1:0]        pix_x;
  logic [Y_W-1:0]        pix_y;
  logic                  dispatch;

  plot_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (req_valid),
    .push_data ({req_x, req_y, req_colour}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign req_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty || clear_pending_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

  // Next-state, pixel generation and the shared "pick next operation" step
  // used from IDLE, at the end of a cell and at the end of a sweep.
  always_comb begin
    state_d         = state_q;
    offset_d        = offset_q;
    sweep_x_d       = sweep_x_q;
    sweep_y_d       = sweep_y_q;
    cur_d           = cur_q;
    clear_pending_d = clear_pending_q || clear_req;
    vga_x_d         = vga_x_q;
    vga_y_d         = vga_y_q;
    vga_colour_d    = vga_colour_q;
    vga_plot_d      = 1'b0;
    last_d          = 1'b0;
    done_d          = last_q;
    fifo_pop        = 1'b0;
    dispatch        = 1'b0;
    pix_x           = cur_q.x + X_W'(offset_q[1:0]);
    pix_y           = cur_q.y + Y_W'(offset_q[3:2]);

    case (state_q)
      ST_IDLE: dispatch = 1'b1;
      ST_DRAW: begin
        vga_x_d      = pix_x;
        vga_y_d      = pix_y;
        vga_colour_d = cur_q.colour;
        vga_plot_d   = ({1'b0, pix_x} < X_LIMIT) && ({1'b0, pix_y} < Y_LIMIT);
        offset_d     = offset_q + 4'd1;
        if (offset_q == OFF_LAST) begin
          last_d   = 1'b1;
          dispatch = 1'b1;
        end
      end
      ST_CLEAR: begin
        vga_x_d      = sweep_x_q;
        vga_y_d      = sweep_y_q;
        vga_colour_d = CLEAR_COLOUR;
        vga_plot_d   = 1'b1;
        if (sweep_x_q == X_LAST) begin
          sweep_x_d = '0;
          if (sweep_y_q == Y_LAST) begin
            last_d   = 1'b1;
            dispatch = 1'b1;
          end else begin
            sweep_y_d = sweep_y_q + 1'b1;
          end
        end else begin
          sweep_x_d = sweep_x_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending clear always wins over queued cells; the queue is kept.
    if (dispatch) begin
      if (clear_pending_q) begin
        state_d         = ST_CLEAR;
        clear_pending_d = clear_req;
        sweep_x_d       = '0;
        sweep_y_d       = '0;
      end else if (!fifo_empty) begin
        state_d  = ST_DRAW;
        fifo_pop = 1'b1;
        cur_d    = plot_req_t'(fifo_head);
        offset_d = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      offset_q        <= '0;
      sweep_x_q       <= '0;
      sweep_y_q       <= '0;
      cur_q           <= '0;
      clear_pending_q <= 1'b0;
      vga_x_q         <= '0;
      vga_y_q         <= '0;
      vga_colour_q    <= '0;
      vga_plot_q      <= 1'b0;
      last_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      offset_q        <= offset_d;
      sweep_x_q       <= sweep_x_d;
      sweep_y_q       <= sweep_y_d;
      cur_q           <= cur_d;
      clear_pending_q <= clear_pending_d;
      vga_x_q         <= vga_x_d;
      vga_y_q         <= vga_y_d;
      vga_colour_q    <= vga_colour_d;
      vga_plot_q      <= vga_plot_d;
      last_q          <= last_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_block_plot_engine.sv
// Bench for block_plot_engine: an operation-level model (queue of expected
// pixels per operation) checked every cycle, plus directed literal checks.
module tb_block_plot_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;
  logic       clear_req;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  block_plot_engine dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .clear_req  (clear_req),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  pix_t        pixq[$];
  logic [17:0] cellq[$];
  bit          m_pend;
  bit          m_done_next;
  bit          exp_active, exp_plot, exp_done;
  logic [7:0]  exp_x;
  logic [6:0]  exp_y;
  logic [2:0]  exp_c;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic add_cell(input logic [17:0] r);
    logic [7:0] cx;
    logic [6:0] cy;
    pix_t       e;
    cx = r[17:10];
    cy = r[9:3];
    for (int k = 0; k < 16; k++) begin
      e.x = 8'(int'(cx) + (k % 4));
      e.y = 7'(int'(cy) + (k / 4));
      e.c = r[2:0];
      e.p = (int'(e.x) < 160) && (int'(e.y) < 120);
      pixq.push_back(e);
    end
  endtask

  task automatic add_clear();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        pixq.push_back('{x: 8'(xx), y: 7'(yy), c: 3'b000, p: 1'b1});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each edge emits the next expected pixel of the current operation; when
  // nothing is in progress or the last pixel just went out, the next
  // operation is chosen (clear first, then oldest queued cell).
  always @(posedge clk or negedge resetn) begin
    int qsz;
    bit disp;
    pix_t e;
    if (!resetn) begin
      pixq.delete();
      cellq.delete();
      m_pend = 0; m_done_next = 0;
      exp_active = 0; exp_plot = 0; exp_done = 0;
    end else begin
      qsz = cellq.size();
      exp_done = m_done_next;
      m_done_next = 0;
      disp = 0;
      if (pixq.size() > 0) begin
        e = pixq.pop_front();
        exp_active = 1; exp_plot = e.p;
        exp_x = e.x; exp_y = e.y; exp_c = e.c;
        if (pixq.size() == 0) begin
          m_done_next = 1;
          disp = 1;
        end
      end else begin
        exp_active = 0; exp_plot = 0;
        disp = 1;
      end
      if (disp) begin
        if (m_pend) begin
          m_pend = 0;
          add_clear();
        end else if (cellq.size() > 0) begin
          add_cell(cellq.pop_front());
        end
      end
      if (clear_req) m_pend = 1;
      if (req_valid && qsz < 4) cellq.push_back({req_x, req_y, req_colour});
    end
  end

  // ---------------- compare + statistics ----------------
  int plot_cnt, done_cnt, first_plot_cyc, last_plot_cyc, done_cyc;
  int first_x, first_y, last_x, last_y, last_c, cur_run, max_run;
  bit ready_low_seen;

  task automatic clr_stats();
    plot_cnt = 0; done_cnt = 0; first_plot_cyc = -1; last_plot_cyc = -1;
    done_cyc = -1; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    last_c = -1; cur_run = 0; max_run = 0; ready_low_seen = 0;
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_plot", int'(vga_plot), 0);
      chk("rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(req_ready), 1);
    end else begin
      chk("plot", int'(vga_plot), int'(exp_plot));
      chk("done", int'(done), int'(exp_done));
      chk("ready", int'(req_ready), int'(cellq.size() < 4));
      chk("busy", int'(busy), int'(pixq.size() > 0 || cellq.size() > 0 || m_pend));
      if (exp_active) begin
        chk("vga_x", int'(vga_x), int'(exp_x));
        chk("vga_y", int'(vga_y), int'(exp_y));
        chk("vga_colour", int'(vga_colour), int'(exp_c));
      end
    end
    if (vga_plot) begin
      plot_cnt++;
      if (first_plot_cyc < 0) begin
        first_plot_cyc = cyc; first_x = int'(vga_x); first_y = int'(vga_y);
      end
      last_plot_cyc = cyc; last_x = int'(vga_x); last_y = int'(vga_y);
      last_c = int'(vga_colour);
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!req_ready) ready_low_seen = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_cell(input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, output int edge_no);
    int n;
    req_x = x; req_y = y; req_colour = c; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_wait_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;
    edge_no = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || vga_plot || done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", int'(n < budget), 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p, dummy, n;
    resetn = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
    req_colour = '0; clear_req = 1'b0;
    clr_stats();
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_plot", int'(vga_plot), 0);
    @(posedge clk); #3; resetn = 1'b1;
    @(posedge clk); #1;

    // Single in-range cell: latency and coverage.
    clr_stats();
    push_cell(8'd80, 7'd60, 3'b001, p);
    req_valid = 1'b0;
    wait_idle(60);
    chk("cell_plots", plot_cnt, 16);
    chk("cell_first_cyc", first_plot_cyc - p, 2);
    chk("cell_last_cyc", last_plot_cyc - p, 17);
    chk("cell_done_cyc", done_cyc - p, 18);
    chk("cell_done_cnt", done_cnt, 1);
    chk("cell_first_xy", first_x * 256 + first_y, 80 * 256 + 60);
    chk("cell_last_xy", last_x * 256 + last_y, 83 * 256 + 63);
    chk("cell_busy_after", int'(busy), 0);

    // Clipped cell at the bottom-right corner.
    @(posedge clk); #1;
    clr_stats();
    push_cell(8'd158, 7'd118, 3'b110, p);
    req_valid = 1'b0;
    wait_idle(60);
    chk("clip_plots", plot_cnt, 4);
    chk("clip_done_cyc", done_cyc - p, 18);
    chk("clip_last_xy", last_x * 256 + last_y, 159 * 256 + 119);

    // Back-to-back cells: queue fills, plots stay gapless.
    @(posedge clk); #1;
    clr_stats();
    for (int i = 0; i < 6; i++) push_cell(8'(i * 8), 7'd8, 3'(i + 1), dummy);
    req_valid = 1'b0;
    wait_idle(200);
    chk("b2b_run", max_run, 96);
    chk("b2b_done_cnt", done_cnt, 6);
    chk("b2b_ready_low", int'(ready_low_seen), 1);

    // Full-screen clear from idle.
    @(posedge clk); #1;
    clr_stats();
    pulse_clear();
    wait_idle(19400);
    chk("clr_plots", plot_cnt, 19200);
    chk("clr_run", max_run, 19200);
    chk("clr_done_cnt", done_cnt, 1);
    chk("clr_first_xy", first_x * 256 + first_y, 0);
    chk("clr_last_xy", last_x * 256 + last_y, 159 * 256 + 119);

    // Clear arriving mid-cell (offset 7) with two cells queued.
    @(posedge clk); #1;
    clr_stats();
    push_cell(8'd40, 7'd40, 3'b010, p);
    push_cell(8'd100, 7'd20, 3'b011, dummy);
    push_cell(8'd0, 7'd0, 3'b100, dummy);
    req_valid = 1'b0;
    while (cyc < p + 8) begin @(posedge clk); #1; end
    pulse_clear();
    wait_idle(19500);
    chk("mid_plots", plot_cnt, 48 + 19200);
    chk("mid_done_cnt", done_cnt, 4);
    chk("mid_last_xyc", last_x * 4096 + last_y * 8 + last_c, 3 * 4096 + 3 * 8 + 4);

    // Asynchronous reset in the middle of a sweep.
    @(posedge clk); #1;
    clr_stats();
    pulse_clear();
    n = 0;
    while (plot_cnt < 5000 && n < 5200) begin @(negedge clk); n++; end
    chk("rst_reached_5000", int'(plot_cnt >= 5000), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_plot", int'(vga_plot), 0);
    chk("async_xyc", int'({vga_x, vga_y, vga_colour}), 0);
    chk("async_done", int'(done), 0);
    chk("async_ready", int'(req_ready), 1);
    chk("async_busy", int'(busy), 0);
    clr_stats();
    repeat (2) @(negedge clk);
    @(posedge clk); #3; resetn = 1'b1;
    @(posedge clk); #1;
    push_cell(8'd10, 7'd20, 3'b101, p);
    req_valid = 1'b0;
    wait_idle(60);
    chk("post_rst_plots", plot_cnt, 16);
    chk("post_rst_done_cnt", done_cnt, 1);
    chk("post_rst_done_cyc", done_cyc - p, 18);

    // Randomized traffic, including wrap/clip coordinates.
    @(posedge clk); #1;
    for (int i = 0; i < 800; i++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_x      = 8'($urandom_range(0, 255));
      req_y      = 7'($urandom_range(0, 127));
      req_colour = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
